// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-read-port register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    CLEAR    = 2'd1,
    READY    = 2'd2
  } rb_state_t;

  // LSB position of port `port` inside a packed per-port vector of `width`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Bus bundle for reg_bank_mp: write port, packed read ports and status.
interface reg_bank_mp_if #(
  parameter int DW  = 8,
  parameter int AW  = 3,
  parameter int NRD = 3
);
  logic              clear_req;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              ready;
  logic              wr_drop;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_drop
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_drop
  );
endinterface

// File: rtl/reg_bank_clear_fsm.sv
// Sequences reset -> clear sweep -> ready, gates writes and flags dropped ones.
module reg_bank_clear_fsm
  import reg_bank_pkg::*;
#(
  parameter int AW      = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic          ready,
  output logic          wr_drop,
  output logic          clr_we,
  output logic [AW-1:0] clr_cnt,
  output logic          mem_we
);

  rb_state_t     state, state_nxt;
  logic [AW-1:0] cnt_nxt;
  logic          drop_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RESET_ST;
      clr_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
      wr_drop <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    drop_nxt  = wr_en;
    ready     = 1'b0;
    clr_we    = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      RESET_ST: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        clr_we = rst_n;
        // Last index is all-ones; the counter holds there instead of wrapping.
        if (clr_cnt == '1) state_nxt = READY;
        else               cnt_nxt   = clr_cnt + 1'b1;
      end
      READY: begin
        ready    = 1'b1;
        drop_nxt = 1'b0;
        mem_we   = rst_n && wr_en && !(ZERO_R0 && (wr_addr == '0));
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = RESET_ST;
    endcase
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised register bank: one write port, NRD combinational read ports,
// hardware clear sweep, optional write-to-read bypass and hardwired-zero R0.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            AW      = 3,
  parameter int            NRD     = 3,
  parameter bit            BYPASS  = 1'b1,
  parameter bit            ZERO_R0 = 1'b0,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_bank_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  logic          ready;
  logic          wr_drop;
  logic          clr_we;
  logic          mem_we;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] core [DEPTH];
  logic [NRD-1:0][DW-1:0] rd_vec;

  reg_bank_clear_fsm #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.clear_req),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .ready     (ready),
    .wr_drop   (wr_drop),
    .clr_we    (clr_we),
    .clr_cnt   (clr_cnt),
    .mem_we    (mem_we)
  );

  always_ff @(posedge clk) begin
    if (clr_we)      core[clr_cnt]     <= CLR_VAL;
    else if (mem_we) core[bus.wr_addr] <= bus.wr_data;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = bus.rd_addr[port_lsb(g, AW) +: AW];
    assign hit  = BYPASS && bus.wr_en && (addr == bus.wr_addr);
    // R0 zeroing takes priority over bypass so a write to R0 never leaks through.
    assign rd_vec[g] = !ready                       ? '0          :
                       (ZERO_R0 && (addr == '0))    ? '0          :
                       hit                          ? bus.wr_data :
                                                      core[addr];
  end

  assign bus.rd_data = rd_vec;
  assign bus.ready   = ready;
  assign bus.wr_drop = wr_drop;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp (bypass, no-bypass and zero-R0 builds).
module tb_reg_bank_mp;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  reg_bank_mp_if #(.DW(8), .AW(3), .NRD(3)) ifa ();
  reg_bank_mp_if #(.DW(8), .AW(3), .NRD(3)) ifb ();
  reg_bank_mp_if #(.DW(8), .AW(3), .NRD(4)) ifc ();

  reg_bank_mp #(.DW(8), .AW(3), .NRD(3), .BYPASS(1'b1), .ZERO_R0(1'b0), .CLR_VAL(8'h00))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  reg_bank_mp #(.DW(8), .AW(3), .NRD(3), .BYPASS(1'b0), .ZERO_R0(1'b0), .CLR_VAL(8'h00))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  reg_bank_mp #(.DW(8), .AW(3), .NRD(4), .BYPASS(1'b1), .ZERO_R0(1'b1), .CLR_VAL(8'hC3))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // The no-bypass build sees exactly the same stimulus as the bypass build.
  assign ifb.clear_req = ifa.clear_req;
  assign ifb.wr_en     = ifa.wr_en;
  assign ifb.wr_addr   = ifa.wr_addr;
  assign ifb.wr_data   = ifa.wr_data;
  assign ifb.rd_addr   = ifa.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (ifa.ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ifa.ready); else n_pass++;
    n_checks++; if (ifa.wr_drop !== 1'b0) $display("FAIL reset_wr_drop got=%b exp=0", ifa.wr_drop); else n_pass++;
    ifa.rd_addr = {3'd5, 3'd2, 3'd0};
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_checks++; if (ifa.ready !== 1'b0) $display("FAIL init_ready_low cyc=%0d got=%b exp=0", i, ifa.ready); else n_pass++;
      n_checks++; if (ifa.rd_data !== 24'h0) $display("FAIL init_rd_zero cyc=%0d got=%h exp=000000", i, ifa.rd_data); else n_pass++;
      step();
    end
    n_checks++; if (ifa.ready !== 1'b1) $display("FAIL init_ready_high got=%b exp=1", ifa.ready); else n_pass++;
    n_checks++; if (ifc.ready !== 1'b1) $display("FAIL init_ready_high_c got=%b exp=1", ifc.ready); else n_pass++;
    ifa.rd_addr = {3'd7, 3'd4, 3'd1};
    #1;
    n_checks++; if (ifa.rd_data !== 24'h0) $display("FAIL init_contents got=%h exp=000000", ifa.rd_data); else n_pass++;
  endtask

  task automatic test_write_bypass();
    ifa.wr_en   = 1'b1;
    ifa.wr_addr = 3'd3;
    ifa.wr_data = 8'h5A;
    ifa.rd_addr = {3'd6, 3'd3, 3'd1};
    #1;
    n_checks++; if (ifa.rd_data[15:8] !== 8'h5A) $display("FAIL bypass_hit got=%h exp=5a", ifa.rd_data[15:8]); else n_pass++;
    n_checks++; if (ifb.rd_data[15:8] !== 8'h00) $display("FAIL nobypass_old got=%h exp=00", ifb.rd_data[15:8]); else n_pass++;
    n_checks++; if (ifa.rd_data[7:0] !== 8'h00) $display("FAIL bypass_miss got=%h exp=00", ifa.rd_data[7:0]); else n_pass++;
    step();
    ifa.wr_en   = 1'b0;
    ifa.rd_addr = {3'd0, 3'd0, 3'd3};
    #1;
    n_checks++; if (ifa.rd_data[7:0] !== 8'h5A) $display("FAIL stored_a got=%h exp=5a", ifa.rd_data[7:0]); else n_pass++;
    n_checks++; if (ifb.rd_data[7:0] !== 8'h5A) $display("FAIL stored_b got=%h exp=5a", ifb.rd_data[7:0]); else n_pass++;
    n_checks++; if (ifa.wr_drop !== 1'b0) $display("FAIL ready_wr_drop got=%b exp=0", ifa.wr_drop); else n_pass++;
  endtask

  task automatic test_drop_during_sweep();
    ifa.clear_req = 1'b1;
    step();
    ifa.clear_req = 1'b0;
    step();
    step();
    step();
    n_checks++; if (ifa.ready !== 1'b0) $display("FAIL sweep4_ready got=%b exp=0", ifa.ready); else n_pass++;
    ifa.wr_en   = 1'b1;
    ifa.wr_addr = 3'd2;
    ifa.wr_data = 8'hAB;
    step();
    ifa.wr_en = 1'b0;
    n_checks++; if (ifa.wr_drop !== 1'b1) $display("FAIL drop_pulse got=%b exp=1", ifa.wr_drop); else n_pass++;
    step();
    n_checks++; if (ifa.wr_drop !== 1'b0) $display("FAIL drop_pulse_end got=%b exp=0", ifa.wr_drop); else n_pass++;
    for (int i = 0; i < 20 && ifa.ready !== 1'b1; i++) step();
    n_checks++; if (ifa.ready !== 1'b1) $display("FAIL sweep_timeout got=%b exp=1", ifa.ready); else n_pass++;
    ifa.rd_addr = {3'd3, 3'd2, 3'd2};
    #1;
    n_checks++; if (ifa.rd_data !== 24'h0) $display("FAIL dropped_r2 got=%h exp=000000", ifa.rd_data); else n_pass++;
  endtask

  task automatic test_clear_req();
    for (int r = 1; r < 8; r++) begin
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 3'(r);
      ifa.wr_data = 8'(r * 17);
      step();
    end
    ifa.wr_en   = 1'b0;
    ifa.rd_addr = {3'd7, 3'd4, 3'd1};
    #1;
    n_checks++; if (ifa.rd_data !== 24'h774411) $display("FAIL fill_a got=%h exp=774411", ifa.rd_data); else n_pass++;
    n_checks++; if (ifb.rd_data !== 24'h774411) $display("FAIL fill_b got=%h exp=774411", ifb.rd_data); else n_pass++;
    ifa.clear_req = 1'b1;
    #1;
    n_checks++; if (ifa.ready !== 1'b1) $display("FAIL clr_req_cycle_ready got=%b exp=1", ifa.ready); else n_pass++;
    step();
    ifa.clear_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ifa.ready !== 1'b0) $display("FAIL clr_ready_low cyc=%0d got=%b exp=0", i, ifa.ready); else n_pass++;
      step();
    end
    n_checks++; if (ifa.ready !== 1'b1) $display("FAIL clr_ready_high got=%b exp=1", ifa.ready); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      ifa.rd_addr = {3'd0, 3'd0, 3'(k)};
      #1;
      n_checks++; if (ifa.rd_data[7:0] !== 8'h00) $display("FAIL cleared_r%0d got=%h exp=00", k, ifa.rd_data[7:0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    ifa.clear_req = 1'b1;
    step();
    ifa.clear_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n       = 1'b0;
    ifa.wr_en   = 1'b1;
    ifa.wr_addr = 3'd5;
    ifa.wr_data = 8'h99;
    step();
    ifa.wr_en = 1'b0;
    n_checks++; if (ifa.ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", ifa.ready); else n_pass++;
    n_checks++; if (ifa.wr_drop !== 1'b0) $display("FAIL midrst_wr_drop got=%b exp=0", ifa.wr_drop); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (ifa.ready !== 1'b0) $display("FAIL restart_ready_low cyc=%0d got=%b exp=0", i, ifa.ready); else n_pass++;
      step();
    end
    n_checks++; if (ifa.ready !== 1'b1) $display("FAIL restart_ready_high got=%b exp=1", ifa.ready); else n_pass++;
    ifa.rd_addr = {3'd5, 3'd5, 3'd5};
    #1;
    n_checks++; if (ifa.rd_data !== 24'h0) $display("FAIL restart_r5 got=%h exp=000000", ifa.rd_data); else n_pass++;
  endtask

  task automatic test_zero_r0();
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = 3'd0;
    ifc.wr_data = 8'hFF;
    ifc.rd_addr = {4{3'd0}};
    #1;
    n_checks++; if (ifc.rd_data !== 32'h0) $display("FAIL r0_bypass got=%h exp=00000000", ifc.rd_data); else n_pass++;
    step();
    ifc.wr_en = 1'b0;
    #1;
    n_checks++; if (ifc.wr_drop !== 1'b0) $display("FAIL r0_wr_drop got=%b exp=0", ifc.wr_drop); else n_pass++;
    n_checks++; if (ifc.rd_data !== 32'h0) $display("FAIL r0_stored got=%h exp=00000000", ifc.rd_data); else n_pass++;
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = 3'd7;
    ifc.wr_data = 8'hFF;
    ifc.rd_addr = {4{3'd7}};
    #1;
    n_checks++; if (ifc.rd_data !== 32'hFFFFFFFF) $display("FAIL r7_bypass_all got=%h exp=ffffffff", ifc.rd_data); else n_pass++;
    step();
    ifc.wr_en   = 1'b0;
    ifc.rd_addr = {3'd7, 3'd0, 3'd5, 3'd5};
    #1;
    n_checks++; if (ifc.rd_data !== 32'hFF00C3C3) $display("FAIL c_readback got=%h exp=ff00c3c3", ifc.rd_data); else n_pass++;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    ifa.clear_req = 1'b0;
    ifa.wr_en     = 1'b0;
    ifa.wr_addr   = '0;
    ifa.wr_data   = '0;
    ifa.rd_addr   = '0;
    ifc.clear_req = 1'b0;
    ifc.wr_en     = 1'b0;
    ifc.wr_addr   = '0;
    ifc.wr_data   = '0;
    ifc.rd_addr   = '0;
    test_reset();
    test_write_bypass();
    test_drop_during_sweep();
    test_clear_req();
    test_reset_mid_sweep();
    test_zero_r0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
